// File: rtl/instr_fetch_unit_if.sv
// Interface bundling PC control, instruction memory and decode handshake signals of
// instr_fetch_unit. master = fetch unit side, slave = surrounding pipeline/memory side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              pc_ctrl;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              fetch_err;

    modport master (
        input  run, pc, flush, imem_ack, imem_data, instr_ready,
        output pc_ctrl, imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err
    );

    modport slave (
        output run, pc, flush, imem_ack, imem_data, instr_ready,
        input  pc_ctrl, imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sample, imem req/ack read, valid/ready hold for decode, flush drain.
// Optional FETCH_TIMEOUT_EN adds a sticky fetch_err on a missing imem_ack.
module instr_fetch_unit #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {StIdle, StReq, StDrain, StFull} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              pc_ctrl_q, pc_ctrl_d;
    logic              reload_q, reload_d;
    logic              req;
    logic              timeout;

    // After a flush that coincides with the state change, the PC only shows the target one
    // cycle later; reload_q spends that cycle latching it with the request held off.
    assign req = ((state_q == StReq) && !reload_q) || (state_q == StDrain);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    logic [TimerW-1:0] timer_q;
    logic              err_q;

    assign timeout = req && !bus.imem_ack && (timer_q == TimerW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (!req || bus.imem_ack) timer_q <= '0;
            else                      timer_q <= timer_q + TimerW'(1);
            if (timeout) err_q <= 1'b1;
        end
    end

    assign bus.fetch_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
    assign bus.fetch_err  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        pc_ctrl_d = 1'b0;
        reload_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                addr_d = bus.pc;
                if (bus.run) state_d = StReq;
            end
            StReq: begin
                if (reload_q) begin
                    addr_d   = bus.pc;
                    reload_d = bus.flush;
                end else if (bus.imem_ack && bus.flush) begin
                    reload_d = 1'b1;
                end else if (bus.imem_ack) begin
                    state_d   = StFull;
                    instr_d   = bus.imem_data;
                    ipc_d     = addr_q;
                    valid_d   = 1'b1;
                    pc_ctrl_d = 1'b1;
                end else if (timeout) begin
                    state_d = StIdle;
                end else if (bus.flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (bus.imem_ack) begin
                    state_d  = StReq;
                    addr_d   = bus.pc;
                    reload_d = bus.flush;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StFull: begin
                if (bus.flush) begin
                    valid_d  = 1'b0;
                    state_d  = bus.run ? StReq : StIdle;
                    reload_d = bus.run;
                end else if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    state_d = bus.run ? StReq : StIdle;
                    // Accepted in the pc_ctrl cycle: the PC increments at this same edge.
                    addr_d  = pc_ctrl_q ? bus.pc + ADDR_W'(4) : bus.pc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            instr_q   <= '0;
            ipc_q     <= '0;
            valid_q   <= 1'b0;
            pc_ctrl_q <= 1'b0;
            reload_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
            valid_q   <= valid_d;
            pc_ctrl_q <= pc_ctrl_d;
            reload_q  <= reload_d;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_ctrl     = pc_ctrl_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table for fetch/back-pressure/run, plus
// hand-written flush, reset and (with FETCH_TIMEOUT_EN) timeout sequences.
module tb_instr_fetch_unit;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    instr_fetch_unit_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    instr_fetch_unit #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    typedef struct {
        logic        run;
        logic [4:0]  pc;
        logic        flush;
        logic        ack;
        logic [31:0] data;
        logic        ready;
        logic        req;
        logic [4:0]  addr;
        logic        pcc;
        logic        valid;
        logic [31:0] instr;
        logic [4:0]  ipc;
    } vec_t;

    localparam int NVec = 17;
    vec_t vecs[NVec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
        else             passed++;
    endtask

    task automatic drive(input logic r, input logic [4:0] p, input logic f, input logic a,
                         input logic [31:0] d, input logic rdy);
        @(negedge clk);
        bus.run         = r;
        bus.pc          = p;
        bus.flush       = f;
        bus.imem_ack    = a;
        bus.imem_data   = d;
        bus.instr_ready = rdy;
        #1;
    endtask

    task automatic expect_req(input string tag, input logic r, input logic [4:0] a);
        check({tag, " imem_req"}, 32'(bus.imem_req), 32'(r));
        check({tag, " imem_addr"}, 32'(bus.imem_addr), 32'(a));
    endtask

    task automatic expect_out(input string tag, input logic v, input logic p);
        check({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(v));
        check({tag, " pc_ctrl"}, 32'(bus.pc_ctrl), 32'(p));
    endtask

    initial begin
        passed = 0;
        total  = 0;
        // Cols: run pc flush ack data ready | req addr pc_ctrl valid instr instr_pc
        vecs[0]  = '{1'b1, 5'd0,  1'b0, 1'b0, 32'h0,        1'b0,
                     1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        5'd0};
        vecs[1]  = '{1'b1, 5'd0,  1'b0, 1'b0, 32'h0,        1'b0,
                     1'b1, 5'd0,  1'b0, 1'b0, 32'h0,        5'd0};
        vecs[2]  = '{1'b1, 5'd0,  1'b0, 1'b1, 32'hDEADBEEF, 1'b0,
                     1'b1, 5'd0,  1'b0, 1'b0, 32'h0,        5'd0};
        vecs[3]  = '{1'b1, 5'd0,  1'b0, 1'b0, 32'h0,        1'b0,
                     1'b0, 5'd0,  1'b1, 1'b1, 32'hDEADBEEF, 5'd0};
        for (int i = 4; i < 8; i++)
            vecs[i] = '{1'b1, 5'd4, 1'b0, 1'b0, 32'h0,      1'b0,
                        1'b0, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF, 5'd0};
        vecs[8]  = '{1'b1, 5'd4,  1'b0, 1'b0, 32'h0,        1'b1,
                     1'b0, 5'd0,  1'b0, 1'b1, 32'hDEADBEEF, 5'd0};
        vecs[9]  = '{1'b1, 5'd4,  1'b0, 1'b0, 32'h0,        1'b0,
                     1'b1, 5'd4,  1'b0, 1'b0, 32'hDEADBEEF, 5'd0};
        vecs[10] = '{1'b1, 5'd4,  1'b0, 1'b1, 32'hCAFEF00D, 1'b0,
                     1'b1, 5'd4,  1'b0, 1'b0, 32'hDEADBEEF, 5'd0};
        vecs[11] = '{1'b1, 5'd4,  1'b0, 1'b0, 32'h0,        1'b1,
                     1'b0, 5'd4,  1'b1, 1'b1, 32'hCAFEF00D, 5'd4};
        vecs[12] = '{1'b1, 5'd8,  1'b0, 1'b1, 32'h12345678, 1'b0,
                     1'b1, 5'd8,  1'b0, 1'b0, 32'hCAFEF00D, 5'd4};
        vecs[13] = '{1'b0, 5'd8,  1'b0, 1'b0, 32'h0,        1'b0,
                     1'b0, 5'd8,  1'b1, 1'b1, 32'h12345678, 5'd8};
        vecs[14] = '{1'b0, 5'd12, 1'b0, 1'b0, 32'h0,        1'b1,
                     1'b0, 5'd8,  1'b0, 1'b1, 32'h12345678, 5'd8};
        vecs[15] = '{1'b0, 5'd12, 1'b0, 1'b0, 32'h0,        1'b0,
                     1'b0, 5'd12, 1'b0, 1'b0, 32'h12345678, 5'd8};
        vecs[16] = '{1'b0, 5'd12, 1'b0, 1'b0, 32'h0,        1'b0,
                     1'b0, 5'd12, 1'b0, 1'b0, 32'h12345678, 5'd8};

        // Reset with stray run/ack activity that must be ignored.
        rst = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1);
        drive(1'b1, 5'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1);
        expect_req("reset", 1'b0, 5'd0);
        expect_out("reset", 1'b0, 1'b0);
        check("reset instr", bus.instr, 32'h0);
        check("reset instr_pc", 32'(bus.instr_pc), 32'h0);
        check("reset fetch_err", 32'(bus.fetch_err), 32'h0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < NVec; i++) begin
            drive(vecs[i].run, vecs[i].pc, vecs[i].flush, vecs[i].ack, vecs[i].data,
                  vecs[i].ready);
            expect_req($sformatf("v%0d", i), vecs[i].req, vecs[i].addr);
            expect_out($sformatf("v%0d", i), vecs[i].valid, vecs[i].pcc);
            check($sformatf("v%0d instr", i), bus.instr, vecs[i].instr);
            check($sformatf("v%0d instr_pc", i), 32'(bus.instr_pc), 32'(vecs[i].ipc));
        end

        // Flush while waiting in REQ; ack arrives three cycles later and is dropped.
        drive(1'b1, 5'd12, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_req("flreq idle", 1'b0, 5'd12);
        drive(1'b1, 5'd12, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_req("flreq flush", 1'b1, 5'd12);
        drive(1'b1, 5'd16, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_req("flreq drain1", 1'b1, 5'd12);
        expect_out("flreq drain1", 1'b0, 1'b0);
        drive(1'b1, 5'd16, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_req("flreq drain2", 1'b1, 5'd12);
        drive(1'b1, 5'd16, 1'b0, 1'b1, 32'h11111111, 1'b0);
        expect_req("flreq ack", 1'b1, 5'd12);
        drive(1'b1, 5'd16, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_req("flreq refetch", 1'b1, 5'd16);
        expect_out("flreq refetch", 1'b0, 1'b0);
        drive(1'b1, 5'd16, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
        expect_out("flreq ack2", 1'b0, 1'b0);
        drive(1'b1, 5'd16, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_out("flreq full", 1'b1, 1'b1);
        check("flreq instr", bus.instr, 32'hA5A5A5A5);
        check("flreq instr_pc", 32'(bus.instr_pc), 32'd16);

        // Flush in FULL together with instr_ready: word dropped, refetch from target 28.
        drive(1'b1, 5'd20, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_out("flfull flush", 1'b1, 1'b0);
        drive(1'b1, 5'd28, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_out("flfull after", 1'b0, 1'b0);

        // Ack and flush in the same cycle: data discarded, refetch from target 4.
        drive(1'b1, 5'd28, 1'b1, 1'b1, 32'h0BADF00D, 1'b1);
        expect_req("flack req", 1'b1, 5'd28);
        drive(1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_out("flack after", 1'b0, 1'b0);
        drive(1'b1, 5'd4, 1'b0, 1'b1, 32'h77777777, 1'b1);
        expect_req("flack refetch", 1'b1, 5'd4);
        expect_out("flack refetch", 1'b0, 1'b0);
        drive(1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_out("flack full", 1'b1, 1'b1);
        check("flack instr", bus.instr, 32'h77777777);
        check("flack instr_pc", 32'(bus.instr_pc), 32'd4);

        // Reset in the middle of a request; the late ack must be ignored.
        drive(1'b1, 5'd8, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_req("midrst req", 1'b1, 5'd8);
        rst = 1'b0;
        drive(1'b0, 5'd8, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
        expect_req("midrst in", 1'b0, 5'd0);
        expect_out("midrst in", 1'b0, 1'b0);
        check("midrst instr", bus.instr, 32'h0);
        rst = 1'b1;
        drive(1'b0, 5'd8, 1'b0, 1'b1, 32'hEEEEEEEE, 1'b0);
        expect_out("midrst late", 1'b0, 1'b0);
        drive(1'b0, 5'd8, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_req("midrst idle", 1'b0, 5'd8);
        expect_out("midrst idle", 1'b0, 1'b0);
        check("midrst instr2", bus.instr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        drive(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
            check($sformatf("tmo c%0d imem_req", k), 32'(bus.imem_req), 32'h1);
            check($sformatf("tmo c%0d fetch_err", k), 32'(bus.fetch_err), 32'h0);
        end
        drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("tmo err set", 32'(bus.fetch_err), 32'h1);
        check("tmo req drop", 32'(bus.imem_req), 32'h0);
        drive(1'b0, 5'd0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("tmo sticky", 32'(bus.fetch_err), 32'h1);
        expect_out("tmo late ack", 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("tmo rst clear", 32'(bus.fetch_err), 32'h0);
        rst = 1'b1;
`else
        check("fetch_err tied", 32'(bus.fetch_err), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
